// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// cpu_sequencer : 3-cycle IDLE/EXEC/WB instruction sequencer for a 74181-style
//                 ALU datapath; owns carry/zero flags and write-back control.
// Revision 1.0
// ============================================================================
module cpu_sequencer #(
  parameter  int DATA_WIDTH = 16,
  parameter  int NUM_REGS   = 8,
  localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [3:0]            instr_op,
  input  logic [ADDR_WIDTH-1:0] instr_rd,
  input  logic [ADDR_WIDTH-1:0] instr_rs1,
  input  logic [ADDR_WIDTH-1:0] instr_rs2,
  input  logic                  instr_imm_sel,
  input  logic [DATA_WIDTH-1:0] instr_imm,
  output logic                  reg_write_enable,
  output logic [ADDR_WIDTH-1:0] reg_write_addr,
  output logic [DATA_WIDTH-1:0] reg_write_data,
  output logic [ADDR_WIDTH-1:0] reg_read_addr1,
  output logic [ADDR_WIDTH-1:0] reg_read_addr2,
  output logic [3:0]            alu_comm,
  output logic                  alu_mode,
  output logic                  alu_cin,
  output logic                  b_source_sel,
  output logic [DATA_WIDTH-1:0] alu_b_imm,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_cout,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  flag_c,
  output logic                  flag_z,
  output logic                  illegal
);

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_ADC = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_SBC = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_NOT = 4'd8;
  localparam logic [3:0] OP_MOV = 4'd9;
  localparam logic [3:0] OP_DEC = 4'd10;
  localparam logic [3:0] OP_INC = 4'd11;
  localparam logic [3:0] OP_DBL = 4'd12;
  localparam logic [3:0] OP_CMP = 4'd13;
  localparam logic [3:0] OP_LDI = 4'd14;
  localparam logic [3:0] OP_ILL = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              op_q;
  logic [ADDR_WIDTH-1:0]   rd_q, rs1_q, rs2_q;
  logic                    imm_sel_q;
  logic [DATA_WIDTH-1:0]   imm_q;
  logic [3:0]              comm_q, comm_d;
  logic                    mode_q, mode_d;
  logic                    cin_q, cin_d;
  logic [DATA_WIDTH-1:0]   result_q;
  logic                    cand_q;
  logic                    flag_c_q, flag_z_q;
  logic                    accept;
  logic                    op_writes, op_arith, op_logic;

  assign accept = instr_valid && (state_q == S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Cn is active-low on the ALU, so a set carry flag is presented as cin=0.
  always_comb begin
    comm_d = 4'b0000;
    mode_d = 1'b0;
    cin_d  = 1'b0;
    case (instr_op)
      OP_ADD:         begin comm_d = 4'b1001; mode_d = 1'b0; cin_d = 1'b1;      end
      OP_ADC:         begin comm_d = 4'b1001; mode_d = 1'b0; cin_d = ~flag_c_q; end
      OP_SUB, OP_CMP: begin comm_d = 4'b0110; mode_d = 1'b0; cin_d = 1'b0;      end
      OP_SBC:         begin comm_d = 4'b0110; mode_d = 1'b0; cin_d = ~flag_c_q; end
      OP_AND:         begin comm_d = 4'b1011; mode_d = 1'b1; cin_d = 1'b1;      end
      OP_OR:          begin comm_d = 4'b1110; mode_d = 1'b1; cin_d = 1'b1;      end
      OP_XOR:         begin comm_d = 4'b0110; mode_d = 1'b1; cin_d = 1'b1;      end
      OP_NOT:         begin comm_d = 4'b0000; mode_d = 1'b1; cin_d = 1'b1;      end
      OP_MOV:         begin comm_d = 4'b1010; mode_d = 1'b1; cin_d = 1'b1;      end
      OP_DEC:         begin comm_d = 4'b1111; mode_d = 1'b0; cin_d = 1'b1;      end
      OP_INC:         begin comm_d = 4'b0000; mode_d = 1'b0; cin_d = 1'b0;      end
      OP_DBL:         begin comm_d = 4'b1100; mode_d = 1'b0; cin_d = 1'b1;      end
      default:        begin comm_d = 4'b0000; mode_d = 1'b0; cin_d = 1'b0;      end
    endcase
  end

  always_comb begin
    op_writes = 1'b0;
    op_arith  = 1'b0;
    op_logic  = 1'b0;
    case (op_q)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_DEC, OP_INC, OP_DBL: begin
        op_writes = 1'b1;
        op_arith  = 1'b1;
      end
      OP_CMP: op_arith = 1'b1;
      OP_AND, OP_OR, OP_XOR, OP_NOT, OP_MOV: begin
        op_writes = 1'b1;
        op_logic  = 1'b1;
      end
      OP_LDI:  op_writes = 1'b1;
      default: op_writes = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q      <= OP_NOP;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_sel_q <= 1'b0;
      imm_q     <= '0;
      comm_q    <= 4'b0000;
      mode_q    <= 1'b0;
      cin_q     <= 1'b0;
      result_q  <= '0;
      cand_q    <= 1'b0;
      flag_c_q  <= 1'b0;
      flag_z_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q      <= instr_op;
        rd_q      <= instr_rd;
        rs1_q     <= instr_rs1;
        rs2_q     <= instr_rs2;
        imm_sel_q <= instr_imm_sel;
        imm_q     <= instr_imm;
        comm_q    <= comm_d;
        mode_q    <= mode_d;
        cin_q     <= cin_d;
      end
      if (state_q == S_EXEC) begin
        result_q <= (op_q == OP_LDI) ? imm_q : alu_result;
        cand_q   <= ~alu_cout;
      end
      if (state_q == S_WB) begin
        if (op_arith)             flag_c_q <= cand_q;
        if (op_arith || op_logic) flag_z_q <= (result_q == '0);
      end
    end
  end

  logic active, in_wb;
  assign active = (state_q != S_IDLE);
  assign in_wb  = (state_q == S_WB);

  assign instr_ready      = (state_q == S_IDLE);
  assign reg_read_addr1   = active ? rs1_q : '0;
  assign reg_read_addr2   = active ? rs2_q : '0;
  assign alu_comm         = active ? comm_q : 4'b0000;
  assign alu_mode         = active & mode_q;
  assign alu_cin          = active & cin_q;
  assign b_source_sel     = active & imm_sel_q;
  assign alu_b_imm        = active ? imm_q : '0;
  assign reg_write_enable = in_wb & op_writes;
  assign reg_write_addr   = in_wb ? rd_q : '0;
  assign reg_write_data   = in_wb ? result_q : '0;
  assign done             = in_wb;
  assign illegal          = in_wb & (op_q == OP_ILL);
  assign result           = result_q;
  assign flag_c           = flag_c_q;
  assign flag_z           = flag_z_q;

endmodule
`default_nettype wire
